// File: rtl/stream_pkg.sv
// Shared mask helpers for the stream width converters.
// A mask is passed zero-extended to MASK_MAX bits.
package stream_pkg;

  localparam int unsigned MASK_MAX = 32;

  function automatic logic is_onehot(input logic [MASK_MAX-1:0] mask);
    return (mask != '0) && ((mask & (mask - MASK_MAX'(1))) == '0);
  endfunction

  function automatic int unsigned lowest_set_idx(input logic [MASK_MAX-1:0] mask);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MASK_MAX; i++) begin
      if (mask[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_downsize_if.sv
// Wide-in / narrow-out stream bundle for stream_downsize.
// The slave modport is the converter; the master modport is its environment.
interface stream_downsize_if #(
  parameter int unsigned T_DATA_WIDTH = 4,
  parameter int unsigned T_DATA_RATIO = 2
);
  logic [T_DATA_WIDTH-1:0] s_data [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] s_keep;
  logic                    s_last;
  logic                    s_valid;
  logic                    s_ready;
  logic [T_DATA_WIDTH-1:0] m_data;
  logic                    m_last;
  logic                    m_valid;
  logic                    m_ready;

  modport master (
    output s_data, s_keep, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_last, m_valid
  );

  modport slave (
    input  s_data, s_keep, s_last, s_valid, m_ready,
    output s_ready, m_data, m_last, m_valid
  );
endinterface

// File: rtl/stream_downsize_word_picker.sv
// Picks the next word to emit from the remaining-keep mask:
// its index, a mask isolating it, and whether it is the only one left.
module downsize_word_picker
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_RATIO = 2
) (
  input  logic [T_DATA_RATIO-1:0]         pend,
  output logic [$clog2(T_DATA_RATIO)-1:0] sel,
  output logic [T_DATA_RATIO-1:0]         clr,
  output logic                            onehot
);
  localparam int unsigned SEL_W = $clog2(T_DATA_RATIO);

  logic [MASK_MAX-1:0] wide;

  always_comb begin
    wide   = MASK_MAX'(pend);
    sel    = SEL_W'(lowest_set_idx(wide));
    // two's-complement trick isolates the lowest set bit
    clr    = pend & (~pend + T_DATA_RATIO'(1));
    onehot = is_onehot(wide);
  end
endmodule

// File: rtl/stream_downsize.sv
// Serialises a wide beat into narrow words, emitting only kept words
// lowest index first; the last kept word carries the packet's last flag.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 4,
  parameter int unsigned T_DATA_RATIO = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  stream_downsize_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(T_DATA_RATIO);

  typedef logic [T_DATA_WIDTH-1:0] word_t;

  word_t                   data_q [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] pend_q;
  logic                    last_q;

  logic [SEL_W-1:0]        sel;
  logic [T_DATA_RATIO-1:0] clr;
  logic                    onehot;
  logic                    ready;
  logic                    accept;
  logic                    handshake;

  downsize_word_picker #(
    .T_DATA_RATIO(T_DATA_RATIO)
  ) picker (
    .pend  (pend_q),
    .sel   (sel),
    .clr   (clr),
    .onehot(onehot)
  );

  // ready also while the final pending word leaves, so beats stream without a bubble
  always_comb begin
    ready       = (pend_q == '0) | (bus.m_ready & onehot);
    accept      = bus.s_valid & ready;
    handshake   = (|pend_q) & bus.m_ready;
    bus.s_ready = ready;
    bus.m_valid = |pend_q;
    bus.m_data  = data_q[sel];
    bus.m_last  = last_q & onehot;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      last_q <= 1'b0;
      for (int unsigned i = 0; i < T_DATA_RATIO; i++) data_q[i] <= '0;
    end else if (accept) begin
      pend_q <= bus.s_keep;
      last_q <= bus.s_last;
      for (int unsigned i = 0; i < T_DATA_RATIO; i++) data_q[i] <= bus.s_data[i];
    end else if (handshake) begin
      pend_q <= pend_q & ~clr;
    end
  end
endmodule

// File: tb/tb_stream_downsize.sv
// Bench for stream_downsize: a queue model of the remaining kept words is
// compared against the outputs every cycle, plus literal expected word logs.
module tb_stream_downsize;
  localparam int unsigned W = 4;
  localparam int unsigned R = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_downsize_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus ();

  stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } nword_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic        model_on = 1'b0;
  int          ready_mode = 0;

  nword_t      rem[$];
  nword_t      log_q[$];
  int unsigned log_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sink ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random
  initial begin : ready_drv
    logic [3:0] pat;
    int         pidx;
    pat  = 4'b1001;
    pidx = 0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          bus.m_ready = pat[pidx];
          pidx = (pidx + 1) % 4;
        end
        2: bus.m_ready = 1'($urandom_range(0, 1));
        default: begin
          bus.m_ready = 1'b1;
          pidx = 0;
        end
      endcase
    end
  end

  // reference model and per-cycle compare
  initial begin : model
    logic exp_valid;
    logic exp_sready;
    int   hi;
    exp_valid  = 1'b0;
    exp_sready = 1'b1;
    forever begin
      @(negedge clk);
      if (model_on) begin
        exp_valid  = rem.size() != 0;
        exp_sready = (rem.size() == 0) || (rem.size() == 1 && bus.m_ready);
        check("m_valid", bus.m_valid, exp_valid);
        check("s_ready", bus.s_ready, exp_sready);
        if (exp_valid) begin
          check("m_data", bus.m_data, rem[0].d);
          check("m_last", bus.m_last, rem[0].l);
        end else begin
          check("m_last_idle", bus.m_last, 0);
        end
        if (bus.m_valid && bus.m_ready) begin
          log_q.push_back('{bus.m_data, bus.m_last});
          log_cyc.push_back(cyc);
        end
      end
      @(posedge clk);
      if (rst) begin
        rem.delete();
      end else if (model_on) begin
        if (bus.s_valid && exp_sready) begin
          rem.delete();
          hi = -1;
          for (int i = 0; i < R; i++) if (bus.s_keep[i]) hi = i;
          for (int i = 0; i < R; i++)
            if (bus.s_keep[i]) rem.push_back('{bus.s_data[i], bus.s_last && (i == hi)});
        end else if (exp_valid && bus.m_ready) begin
          void'(rem.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input logic [15:0] words, input logic [3:0] keep, input logic last);
    logic acc;
    bus.s_valid = 1'b1;
    for (int i = 0; i < R; i++) bus.s_data[i] = words[4*i +: 4];
    bus.s_keep = keep;
    bus.s_last = last;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
    end
    check("accept_timeout", acc, 1);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!bus.m_valid) break;
    end
    check("drain_timeout", bus.m_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_log(input string name, input int n, input logic [31:0] words, input logic [7:0] lasts);
    check({name, "_count"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      check({name, "_data"}, log_q[i].d, words[4*i +: 4]);
      check({name, "_last"}, log_q[i].l, lasts[i]);
    end
    log_q.delete();
    log_cyc.delete();
  endtask

  initial begin : main
    int exp_cnt;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_keep  = '0;
    bus.s_last  = 1'b0;
    for (int i = 0; i < R; i++) bus.s_data[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_on = 1'b1;

    @(negedge clk);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_last", bus.m_last, 0);
    @(posedge clk);
    #1;

    // full beat A,B,C,D
    send_beat(16'hDCBA, 4'b1111, 1'b1);
    wait_drain();
    check("full_gap", log_cyc[3] - log_cyc[0], 3);
    expect_log("full", 4, 32'h0000DCBA, 8'b0000_1000);

    // sparse keep: words 1 and 3 only
    send_beat(16'h4321, 4'b0101, 1'b0);
    wait_drain();
    check("sparse_gap", log_cyc[1] - log_cyc[0], 1);
    expect_log("sparse", 2, 32'h00000031, 8'b0000_0000);

    // backpressure 1,0,0,1,...
    ready_mode = 1;
    send_beat(16'h8765, 4'b1111, 1'b1);
    wait_drain();
    ready_mode = 0;
    expect_log("bp", 4, 32'h00008765, 8'b0000_1000);
    repeat (2) @(posedge clk);
    #1;

    // back-to-back beats
    send_beat(16'h4321, 4'b1111, 1'b0);
    send_beat(16'h8765, 4'b0011, 1'b1);
    wait_drain();
    check("b2b_no_bubble", log_cyc[4] - log_cyc[3], 1);
    expect_log("b2b", 6, 32'h00654321, 8'b0010_0000);

    // all-zero keep beat is swallowed
    send_beat(16'hFFFF, 4'b0000, 1'b1);
    send_beat(16'hEEE9, 4'b0001, 1'b1);
    wait_drain();
    expect_log("zero_keep", 1, 32'h00000009, 8'b0000_0001);

    // reset after two of four words
    send_beat(16'hDCBA, 4'b1111, 1'b1);
    for (int t = 0; t < 50 && log_q.size() < 2; t++) begin
      @(posedge clk);
      #1;
    end
    check("rst_pre_words", log_q.size() >= 2, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", bus.m_valid, 0);
    check("midrst_s_ready", bus.s_ready, 1);
    @(posedge clk);
    #1;
    log_q.delete();
    log_cyc.delete();
    send_beat(16'h4321, 4'b1111, 1'b1);
    wait_drain();
    expect_log("after_rst", 4, 32'h00004321, 8'b0000_1000);

    // randomized traffic with random sink stalls and source gaps
    ready_mode = 2;
    exp_cnt = 0;
    for (int b = 0; b < 300; b++) begin
      logic [3:0] k;
      k = 4'($urandom);
      exp_cnt += $countones(k);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_beat(16'($urandom), k, 1'($urandom));
    end
    wait_drain();
    check("rand_count", log_q.size(), exp_cnt);
    log_q.delete();
    log_cyc.delete();
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
